// File: rtl/mem_responder.sv
// Purpose: single-port word memory answering one byte/halfword/word load or store at a time.
// Latency: store/error response 1 cycle after acceptance, load response READ_LATENCY cycles after.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready, then IDLE next cycle.
module mem_responder #(
    parameter int READ_LATENCY = 2,
    parameter int DEPTH_WORDS  = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    // Access size encoding; 2'b11 is not a legal size and is rejected as an error.
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;
    localparam int         IW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        RESPOND   = 2'd2
    } state_t;

    state_t         state;
    logic [1:0]     cnt;
    logic [IW-1:0]  ld_idx;
    logic [1:0]     ld_off;
    logic [1:0]     ld_width;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           aligned;
    logic           in_range;
    logic           req_ok;
    logic           accept;
    logic           do_store;
    logic [IW-1:0]  req_idx;
    logic [1:0]     req_off;
    logic [3:0]     lane_en;
    logic [31:0]    wdata_sh;

    // Right-justify the addressed bytes of a word and zero everything past the access size.
    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] width);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (width)
            WIDTH_BYTE: load_fmt = {24'd0, sh[7:0]};
            WIDTH_HALF: load_fmt = {16'd0, sh[15:0]};
            default:    load_fmt = sh;
        endcase
    endfunction

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESPOND);
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[IW+1:2];
    assign req_off   = req_addr[1:0];
    assign in_range  = ({2'b00, req_addr[31:2]} < 32'(DEPTH_WORDS));
    assign req_ok    = aligned && in_range;
    assign do_store  = reset && accept && req_ok && req_write;
    assign wdata_sh  = req_wdata << {req_off, 3'b000};

    // Alignment and byte-lane enables for the requested access size.
    always_comb begin
        aligned = 1'b0;
        lane_en = 4'b0000;
        case (req_width)
            WIDTH_BYTE: begin
                aligned = 1'b1;
                lane_en = 4'b0001 << req_off;
            end
            WIDTH_HALF: begin
                aligned = (req_off[0] == 1'b0);
                lane_en = 4'b0011 << req_off;
            end
            WIDTH_WORD: begin
                aligned = (req_off == 2'b00);
                lane_en = 4'b1111;
            end
            default: begin
                aligned = 1'b0;
                lane_en = 4'b0000;
            end
        endcase
    end

    // Storage: stores commit on the acceptance edge; contents survive reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (do_store && lane_en[i]) begin
                mem[req_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    // Request/response sequencing with registered response data and error flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
            ld_idx    <= '0;
            ld_off    <= 2'd0;
            ld_width  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!req_ok) begin
                            state     <= RESPOND;
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else if (req_write) begin
                            state     <= RESPOND;
                            rsp_error <= 1'b0;
                            rsp_rdata <= 32'd0;
                        end else if (READ_LATENCY <= 1) begin
                            state     <= RESPOND;
                            rsp_error <= 1'b0;
                            rsp_rdata <= load_fmt(mem[req_idx], req_off, req_width);
                        end else begin
                            state    <= READ_WAIT;
                            cnt      <= 2'(READ_LATENCY - 1);
                            ld_idx   <= req_idx;
                            ld_off   <= req_off;
                            ld_width <= req_width;
                        end
                    end
                end
                READ_WAIT: begin
                    // The edge on which the counter reaches zero is the capture edge.
                    if (cnt <= 2'd1) begin
                        cnt       <= 2'd0;
                        state     <= RESPOND;
                        rsp_error <= 1'b0;
                        rsp_rdata <= load_fmt(mem[ld_idx], ld_off, ld_width);
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_rdata <= 32'd0;
                        rsp_error <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Purpose: directed vector table plus hand sequences for backpressure, handshake-edge and reset cases.
// Latency: expects store/error responses at acceptance+1 and loads at acceptance+2.
// Backpressure: holds rsp_ready low for several cycles in one sequence; otherwise accepts promptly.
module tb_mem_responder;

    localparam logic [1:0] W_B = 2'b00;
    localparam logic [1:0] W_H = 2'b01;
    localparam logic [1:0] W_W = 2'b10;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_width;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    mem_responder #(.READ_LATENCY(2), .DEPTH_WORDS(1024)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_width (req_width),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] w, input logic [31:0] a,
                                input logic [31:0] d, input logic e, input logic [31:0] rd,
                                input int lat);
        vec_t v;
        v.wr = wr; v.w = w; v.addr = a; v.wdata = d; v.err = e; v.rdata = rd; v.lat = lat;
        return v;
    endfunction

    // Present one request, wait (bounded) for the response, check it, then consume it.
    task automatic run_req(input string nm, input vec_t v);
        int cyc;
        @(negedge clock);
        check({nm, "_ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_width = v.w;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check({nm, "_latency"}, 32'(cyc), 32'(v.lat));
        check({nm, "_rdata"}, rsp_rdata, v.rdata);
        check({nm, "_error"}, 32'(rsp_error), 32'(v.err));
        check({nm, "_ready_busy"}, 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check({nm, "_idle_after"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        vecs[0]  = mk(1, W_W, 32'h100,  32'hDEADBEEF, 0, 32'h0,        1);
        vecs[1]  = mk(0, W_W, 32'h100,  32'h0,        0, 32'hDEADBEEF, 2);
        vecs[2]  = mk(1, W_B, 32'h101,  32'hAAAAAA12, 0, 32'h0,        1);
        vecs[3]  = mk(0, W_H, 32'h100,  32'h0,        0, 32'h000012EF, 2);
        vecs[4]  = mk(0, W_W, 32'h100,  32'h0,        0, 32'hDEAD12EF, 2);
        vecs[5]  = mk(1, W_W, 32'h000,  32'h11223344, 0, 32'h0,        1);
        vecs[6]  = mk(0, W_W, 32'h102,  32'h0,        1, 32'h0,        1);
        vecs[7]  = mk(1, W_H, 32'h001,  32'hFFFF,     1, 32'h0,        1);
        vecs[8]  = mk(0, W_W, 32'h000,  32'h0,        0, 32'h11223344, 2);
        vecs[9]  = mk(0, W_W, 32'h1000, 32'h0,        1, 32'h0,        1);
        vecs[10] = mk(0, W_B, 32'h103,  32'h0,        0, 32'h000000DE, 2);
        vecs[11] = mk(0, W_H, 32'h102,  32'h0,        0, 32'h0000DEAD, 2);
        vecs[12] = mk(1, W_B, 32'hFFF,  32'h123456A5, 0, 32'h0,        1);
        vecs[13] = mk(0, W_B, 32'hFFF,  32'h0,        0, 32'h000000A5, 2);
        vecs[14] = mk(1, W_B, 32'h1000, 32'h77,       1, 32'h0,        1);
        vecs[15] = mk(0, W_H, 32'h003,  32'h0,        1, 32'h0,        1);
        vecs[16] = mk(0, W_W, 32'h100,  32'h0,        0, 32'hDEAD12EF, 2);

        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_width = W_W;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);

        for (int i = 0; i < 17; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: response held for 5 cycles, then a store offered on the handshake edge.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_width = W_W; req_addr = 32'h100;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check("bp_latency", 32'(cyc), 32'd2);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_valid_%0d", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_rdata_%0d", k), rsp_rdata, 32'hDEAD12EF);
            check($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'd0);
            @(negedge clock);
        end
        req_valid = 1'b1; req_write = 1'b1; req_width = W_W;
        req_addr  = 32'h100; req_wdata = 32'hFFFFFFFF;
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("hs_edge_no_accept_valid", 32'(rsp_valid), 32'd0);
        check("hs_edge_idle_ready", 32'(req_ready), 32'd1);

        // Reset while a load is waiting: the load vanishes, storage is kept.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_width = W_W; req_addr = 32'h100;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("rst_in_read_wait", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_no_rsp_%0d", k), 32'(rsp_valid), 32'd0);
            check($sformatf("rst_ready_%0d", k), 32'(req_ready), 32'd1);
            @(negedge clock);
        end
        run_req("after_reset", mk(0, W_W, 32'h100, 32'h0, 0, 32'hDEAD12EF, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 2, meaning cycles from read acceptance to rsp_valid (legal 1..3).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit storage words (byte range 0x000..0xFFF).
REQ-003 The block SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 The block SHALL have port req_addr  input  XLEN  byte address.
REQ-008 The block SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 The block SHALL have port req_width  input  write_width_t  access size (write_byte, write_halfword, write_word), used for loads and stores.
REQ-010 The block SHALL have port req_wdata  input  XLEN  store data, low bytes significant.
REQ-011 The block SHALL have port rsp_valid  output  1  response present.
REQ-012 The block SHALL have port rsp_ready  input  1  requester accepts response.
REQ-013 The block SHALL have port rsp_rdata  output  XLEN  load data.
REQ-014 The block SHALL have port rsp_error  output  1  request rejected (misaligned or out of range).

Function
REQ-015 The block SHALL implement states IDLE, READ_WAIT, RESPOND, with at most one request outstanding.
REQ-016 req_ready SHALL be 1 exactly in IDLE; a request is accepted on a rising edge with req_valid && req_ready.
REQ-017 Error check at acceptance: word needs addr[1:0]==0, halfword needs addr[0]==0, and addr[31:2] < DEPTH_WORDS; failure means error.
REQ-018 Error request SHALL go IDLE -> RESPOND, write nothing, present rsp_error=1, rsp_rdata=0 one cycle after acceptance.
REQ-019 Valid store SHALL commit at the acceptance edge, little-endian, only the byte lanes addr[1:0]..addr[1:0]+size-1 modified, from req_wdata low bytes; then RESPOND, rsp_valid one cycle after acceptance, rsp_rdata=0.
REQ-020 Valid load SHALL load a down-counter with READ_LATENCY-1 and go to READ_WAIT (or RESPOND directly when READ_LATENCY=1).
REQ-021 In READ_WAIT the counter SHALL decrement each cycle; at 0 the block captures data and goes to RESPOND, so rsp_valid rises exactly READ_LATENCY cycles after acceptance.
REQ-022 Load data SHALL be the addressed word shifted right by 8*addr[1:0], bytes beyond width zero-filled (no sign extension; requester extends).
REQ-023 Captured load data SHALL reflect storage at capture time; no store can intervene while a load is outstanding.
REQ-024 In RESPOND, rsp_valid=1 and rsp_rdata/rsp_error SHALL stay stable until rsp_ready=1; that edge returns to IDLE.
REQ-025 Outside RESPOND, rsp_valid, rsp_error and rsp_rdata SHALL be 0.
REQ-026 A new request SHALL NOT be accepted on the response handshake edge; earliest acceptance is the following cycle.

Reset
REQ-027 While reset=0 at a rising edge: state IDLE, counter 0, rsp_valid=0, rsp_error=0, rsp_rdata=0; req_ready=1 the first cycle after reset deasserts.
REQ-028 Reset mid-operation SHALL discard any pending load or response with no further write; stores already committed remain.
REQ-029 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-030 Store word 0xDEADBEEF @0x100, then load word @0x100 -> store rsp at acceptance+1, load rsp_valid at acceptance+2, rsp_rdata=0xDEADBEEF, rsp_error=0.
REQ-031 After REQ-030, store byte 0x12 @0x101, load halfword @0x100 -> rsp_rdata=0x000012EF; load word @0x100 -> 0xDEAD12EF.
REQ-032 Load word @0x102 and store halfword @0x001 -> rsp_error=1, rsp_rdata=0 at acceptance+1, storage unchanged.
REQ-033 Load word @0x1000 (DEPTH_WORDS=1024) -> rsp_error=1; req_ready=0 until response consumed.
REQ-034 Hold rsp_ready=0 for 5 cycles after load rsp -> rsp_valid and data stable for 5 cycles, req_ready=0; IDLE the cycle after rsp_ready=1.
REQ-035 Assert reset in READ_WAIT -> no rsp_valid, req_ready=1 after release; prior stored 0xDEAD12EF still read back.
